// File: rtl/eightbit_pkg.sv
// Shared definitions for the interrupt controller slice.
// Contents:
//   intc_reg_t    - device register addresses 0x0..0x4
//   intc_state_t  - handshake FSM states
//   CTRL_*_BIT    - bit positions inside the CONTROL register
//   intc_vector() - handler address of a source index, modulo 2^16
package eightbit_pkg;

    typedef enum logic [3:0] {
        REG_PENDING    = 4'h0,
        REG_MASK       = 4'h1,
        REG_IN_SERVICE = 4'h2,
        REG_CONTROL    = 4'h3,
        REG_STATUS     = 4'h4
    } intc_reg_t;

    typedef enum logic {
        INTC_IDLE = 1'b0,
        INTC_REQ  = 1'b1
    } intc_state_t;

    localparam int CTRL_GLOBAL_EN_BIT = 0;
    localparam int CTRL_NEST_EN_BIT   = 1;

    // Vector = base + index * stride; 16-bit arithmetic wraps naturally.
    function automatic logic [15:0] intc_vector(input logic [15:0] base,
                                                input logic [15:0] stride,
                                                input logic [15:0] index);
        return base + stride * index;
    endfunction

endpackage

// File: rtl/intc_priority_encoder.sv
// Combinational find-lowest-set encoder.
// Ports:
//   req   in  WIDTH  request vector
//   index out IDX_W  position of the lowest set bit (0 when none)
//   valid out 1      at least one bit of req is set
module intc_priority_encoder #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDX_W-1:0] index,
    output logic             valid
);

    // Scan from the top down so the lowest set bit is the last one kept.
    always_comb begin
        index = '0;
        valid = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            index = req[i] ? IDX_W'(i) : index;
            valid = valid | req[i];
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Prioritising, maskable interrupt controller.
// Latches rising edges of device lines into PENDING, arbitrates by fixed
// priority (index 0 highest), tracks in-service levels and hands one winner
// at a time to the FSM together with its 16-bit handler vector.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   irq_in     [WIDTH]    device interrupt lines (level)
//   address/enable/mode   register select, device select, 1 = write
//   data_in/data_out      bus data; data_out is 'z unless enable && !mode
//   irq_req/irq_vector    registered request and handler address to the FSM
//   irq_ack/irq_done      FSM took the request / handler returned (pulses)
module interrupt_controller
    import eightbit_pkg::*;
#(
    parameter int          WIDTH         = 4,
    parameter int          DATA_WIDTH    = 8,
    parameter logic [15:0] VECTOR_BASE   = 16'hFF00,
    parameter int          VECTOR_STRIDE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      irq_in,
    input  logic [3:0]            address,
    input  logic                  enable,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] data_in,
    output wire  [DATA_WIDTH-1:0] data_out,
    output logic                  irq_req,
    output logic [15:0]           irq_vector,
    input  logic                  irq_ack,
    input  logic                  irq_done
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0]      pending_r, mask_r, in_service_r, irq_prev_r;
    logic [WIDTH-1:0]      pending_s, mask_s, in_service_s;
    logic [1:0]            control_r, control_s;
    intc_state_t           state_r, state_s;
    logic [IDX_W-1:0]      winner_r, winner_s;
    logic                  irq_req_r, irq_req_s;
    logic [15:0]           irq_vector_r, irq_vector_s;

    logic [WIDTH-1:0]      edge_s, elig_base_s, nest_mask_s, eligible_s;
    logic [IDX_W-1:0]      win_idx_s, is_idx_s;
    logic                  win_valid_s, is_valid_s, wr_s, ack_s;
    logic [DATA_WIDTH-1:0] rd_data_s, status_s;

    assign edge_s = irq_in & ~irq_prev_r;
    assign wr_s   = enable & mode;
    // An ack only counts while a request is actually outstanding.
    assign ack_s  = irq_ack & (state_r == INTC_REQ);

    intc_priority_encoder #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_win_enc (
        .req   (eligible_s),
        .index (win_idx_s),
        .valid (win_valid_s)
    );

    intc_priority_encoder #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_is_enc (
        .req   (in_service_r),
        .index (is_idx_s),
        .valid (is_valid_s)
    );

    // Bits strictly above the current in-service level in priority (lower index).
    always_comb begin
        nest_mask_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            nest_mask_s[i] = (i < int'(is_idx_s));
        end
    end

    // Eligibility: enabled pending sources, gated by the in-service level.
    always_comb begin
        elig_base_s = pending_r & mask_r & {WIDTH{control_r[CTRL_GLOBAL_EN_BIT]}};
        if (!is_valid_s) begin
            eligible_s = elig_base_s;
        end else if (control_r[CTRL_NEST_EN_BIT]) begin
            eligible_s = elig_base_s & nest_mask_s;
        end else begin
            eligible_s = '0;
        end
    end

    // Next register contents: software writes, ack/done, then edge set last
    // so a fresh edge wins over any clear of the same bit.
    always_comb begin
        pending_s    = pending_r;
        mask_s       = mask_r;
        control_s    = control_r;
        in_service_s = in_service_r;
        if (wr_s) begin
            case (address)
                REG_PENDING: pending_s = pending_r & ~data_in[WIDTH-1:0];
                REG_MASK:    mask_s    = data_in[WIDTH-1:0];
                REG_CONTROL: control_s = data_in[1:0];
                default:     mask_s    = mask_r;
            endcase
        end else begin
            mask_s = mask_r;
        end
        if (irq_done && is_valid_s) begin
            in_service_s[is_idx_s] = 1'b0;
        end else begin
            in_service_s = in_service_r;
        end
        if (ack_s) begin
            pending_s[winner_r]    = 1'b0;
            in_service_s[winner_r] = 1'b1;
        end else begin
            pending_s = pending_s;
        end
        pending_s = pending_s | edge_s;
    end

    // Handshake FSM: next state and registered request outputs.
    always_comb begin
        state_s      = state_r;
        winner_s     = winner_r;
        irq_req_s    = irq_req_r;
        irq_vector_s = irq_vector_r;
        case (state_r)
            INTC_IDLE: begin
                if (win_valid_s) begin
                    state_s      = INTC_REQ;
                    winner_s     = win_idx_s;
                    irq_req_s    = 1'b1;
                    irq_vector_s = intc_vector(VECTOR_BASE, 16'(VECTOR_STRIDE),
                                               16'(win_idx_s));
                end else begin
                    irq_req_s = 1'b0;
                end
            end
            INTC_REQ: begin
                // Ack is checked first so it wins over a same-cycle withdrawal.
                if (ack_s) begin
                    state_s   = INTC_IDLE;
                    irq_req_s = 1'b0;
                end else if (!eligible_s[winner_r]) begin
                    state_s   = INTC_IDLE;
                    irq_req_s = 1'b0;
                end else begin
                    irq_req_s = 1'b1;
                end
            end
            default: begin
                state_s   = INTC_IDLE;
                irq_req_s = 1'b0;
            end
        endcase
    end

    // Register file, edge history and handshake registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r    <= '0;
            mask_r       <= '0;
            in_service_r <= '0;
            control_r    <= 2'b00;
            irq_prev_r   <= '0;
            state_r      <= INTC_IDLE;
            winner_r     <= '0;
            irq_req_r    <= 1'b0;
            irq_vector_r <= 16'h0000;
        end else begin
            pending_r    <= pending_s;
            mask_r       <= mask_s;
            in_service_r <= in_service_s;
            control_r    <= control_s;
            irq_prev_r   <= irq_in;
            state_r      <= state_s;
            winner_r     <= winner_s;
            irq_req_r    <= irq_req_s;
            irq_vector_r <= irq_vector_s;
        end
    end

    // Combinational read mux; unmapped addresses read as zero.
    always_comb begin
        status_s                 = '0;
        status_s[DATA_WIDTH-1]   = irq_req_r;
        status_s[IDX_W-1:0]      = winner_r;
        case (address)
            REG_PENDING:    rd_data_s = DATA_WIDTH'(pending_r);
            REG_MASK:       rd_data_s = DATA_WIDTH'(mask_r);
            REG_IN_SERVICE: rd_data_s = DATA_WIDTH'(in_service_r);
            REG_CONTROL:    rd_data_s = DATA_WIDTH'(control_r);
            REG_STATUS:     rd_data_s = status_s;
            default:        rd_data_s = '0;
        endcase
    end

    assign data_out   = (enable && !mode) ? rd_data_s : {DATA_WIDTH{1'bz}};
    assign irq_req    = irq_req_r;
    assign irq_vector = irq_vector_r;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed, table-driven bench for interrupt_controller.
// Each record is one clock cycle: the inputs driven before the edge, then
// the register read back after the edge and the expected request outputs.
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  irq_in;
    logic [3:0]  address;
    logic        enable;
    logic        mode;
    logic [7:0]  data_in;
    wire  [7:0]  data_out;
    logic        irq_req;
    logic [15:0] irq_vector;
    logic        irq_ack;
    logic        irq_done;

    int checks = 0;
    int errors = 0;

    interrupt_controller dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .address    (address),
        .enable     (enable),
        .mode       (mode),
        .data_in    (data_in),
        .data_out   (data_out),
        .irq_req    (irq_req),
        .irq_vector (irq_vector),
        .irq_ack    (irq_ack),
        .irq_done   (irq_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  irq;
        logic        wr;
        logic [3:0]  waddr;
        logic [7:0]  wdata;
        logic        ack;
        logic        done;
        logic [3:0]  raddr;
        logic        exp_req;
        logic [15:0] exp_vec;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic [3:0] irq, logic wr, logic [3:0] waddr,
                                logic [7:0] wdata, logic ack, logic done, logic [3:0] raddr,
                                logic exp_req, logic [15:0] exp_vec, logic [7:0] exp_rd);
        vec_t v;
        v.rst = rst; v.irq = irq; v.wr = wr; v.waddr = waddr; v.wdata = wdata;
        v.ack = ack; v.done = done; v.raddr = raddr;
        v.exp_req = exp_req; v.exp_vec = exp_vec; v.exp_rd = exp_rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    initial begin
        reset = 1'b1; irq_in = 4'h0; address = 4'h0; enable = 1'b0; mode = 1'b0;
        data_in = 8'h00; irq_ack = 1'b0; irq_done = 1'b0;

        //            rst  irq    wr  wa    wd     ack  done ra    req  vec       rd
        // reset state
        tbl.push_back(mk(1'b1,4'b0000,1'b0,4'h0,8'h00,1'b0,1'b0,4'h0,1'b0,16'h0000,8'h00));
        tbl.push_back(mk(1'b1,4'b0000,1'b0,4'h0,8'h00,1'b0,1'b0,4'h1,1'b0,16'h0000,8'h00));
        // 1: single source 2
        tbl.push_back(mk(1'b0,4'b0000,1'b1,4'h1,8'h0F,1'b0,1'b0,4'h1,1'b0,16'h0000,8'h0F));
        tbl.push_back(mk(1'b0,4'b0000,1'b1,4'h3,8'h01,1'b0,1'b0,4'h3,1'b0,16'h0000,8'h01));
        tbl.push_back(mk(1'b0,4'b0100,1'b0,4'h0,8'h00,1'b0,1'b0,4'h0,1'b0,16'h0000,8'h04));
        tbl.push_back(mk(1'b0,4'b0100,1'b0,4'h0,8'h00,1'b0,1'b0,4'h4,1'b1,16'hFF08,8'h82));
        tbl.push_back(mk(1'b0,4'b0000,1'b0,4'h0,8'h00,1'b0,1'b0,4'h0,1'b1,16'hFF08,8'h04));
        tbl.push_back(mk(1'b0,4'b0000,1'b0,4'h0,8'h00,1'b1,1'b0,4'h2,1'b0,16'h0000,8'h04));
        tbl.push_back(mk(1'b0,4'b0000,1'b0,4'h0,8'h00,1'b0,1'b0,4'h0,1'b0,16'h0000,8'h00));
        tbl.push_back(mk(1'b0,4'b0000,1'b0,4'h0,8'h00,1'b0,1'b1,4'h2,1'b0,16'h0000,8'h00));
        // 2: sources 3 and 1 together, nesting off
        tbl.push_back(mk(1'b0,4'b1010,1'b0,4'h0,8'h00,1'b0,1'b0,4'h0,1'b0,16'h0000,8'h0A));
        tbl.push_back(mk(1'b0,4'b1010,1'b0,4'h0,8'h00,1'b0,1'b0,4'h4,1'b1,16'hFF04,8'h81));
        tbl.push_back(mk(1'b0,4'b1010,1'b0,4'h0,8'h00,1'b1,1'b0,4'h2,1'b0,16'h0000,8'h02));
        tbl.push_back(mk(1'b0,4'b1010,1'b0,4'h0,8'h00,1'b0,1'b0,4'h0,1'b0,16'h0000,8'h08));
        tbl.push_back(mk(1'b0,4'b1010,1'b0,4'h0,8'h00,1'b0,1'b0,4'h4,1'b0,16'h0000,8'h01));
        tbl.push_back(mk(1'b0,4'b1010,1'b0,4'h0,8'h00,1'b0,1'b1,4'h2,1'b0,16'h0000,8'h00));
        tbl.push_back(mk(1'b0,4'b1010,1'b0,4'h0,8'h00,1'b0,1'b0,4'h4,1'b1,16'hFF0C,8'h83));
        tbl.push_back(mk(1'b0,4'b1010,1'b0,4'h0,8'h00,1'b1,1'b0,4'h2,1'b0,16'h0000,8'h08));
        tbl.push_back(mk(1'b0,4'b0000,1'b0,4'h0,8'h00,1'b0,1'b1,4'h2,1'b0,16'h0000,8'h00));
        // 3: nesting on
        tbl.push_back(mk(1'b0,4'b0000,1'b1,4'h3,8'h03,1'b0,1'b0,4'h3,1'b0,16'h0000,8'h03));
        tbl.push_back(mk(1'b0,4'b0100,1'b0,4'h0,8'h00,1'b0,1'b0,4'h0,1'b0,16'h0000,8'h04));
        tbl.push_back(mk(1'b0,4'b0100,1'b0,4'h0,8'h00,1'b0,1'b0,4'h4,1'b1,16'hFF08,8'h82));
        tbl.push_back(mk(1'b0,4'b0100,1'b0,4'h0,8'h00,1'b1,1'b0,4'h2,1'b0,16'h0000,8'h04));
        tbl.push_back(mk(1'b0,4'b0101,1'b0,4'h0,8'h00,1'b0,1'b0,4'h0,1'b0,16'h0000,8'h01));
        tbl.push_back(mk(1'b0,4'b0101,1'b0,4'h0,8'h00,1'b0,1'b0,4'h4,1'b1,16'hFF00,8'h80));
        tbl.push_back(mk(1'b0,4'b0101,1'b0,4'h0,8'h00,1'b1,1'b0,4'h2,1'b0,16'h0000,8'h05));
        tbl.push_back(mk(1'b0,4'b0101,1'b0,4'h0,8'h00,1'b0,1'b1,4'h2,1'b0,16'h0000,8'h04));
        tbl.push_back(mk(1'b0,4'b1101,1'b0,4'h0,8'h00,1'b0,1'b0,4'h0,1'b0,16'h0000,8'h08));
        tbl.push_back(mk(1'b0,4'b1101,1'b0,4'h0,8'h00,1'b0,1'b0,4'h4,1'b0,16'h0000,8'h00));
        tbl.push_back(mk(1'b0,4'b1101,1'b0,4'h0,8'h00,1'b0,1'b0,4'h2,1'b0,16'h0000,8'h04));
        tbl.push_back(mk(1'b0,4'b1101,1'b0,4'h0,8'h00,1'b0,1'b1,4'h2,1'b0,16'h0000,8'h00));
        tbl.push_back(mk(1'b0,4'b1101,1'b0,4'h0,8'h00,1'b0,1'b0,4'h4,1'b1,16'hFF0C,8'h83));
        tbl.push_back(mk(1'b0,4'b1101,1'b0,4'h0,8'h00,1'b1,1'b0,4'h2,1'b0,16'h0000,8'h08));
        tbl.push_back(mk(1'b0,4'b0000,1'b0,4'h0,8'h00,1'b0,1'b1,4'h2,1'b0,16'h0000,8'h00));
        // 4: withdrawal by MASK write, then by PENDING clear
        tbl.push_back(mk(1'b0,4'b0010,1'b0,4'h0,8'h00,1'b0,1'b0,4'h0,1'b0,16'h0000,8'h02));
        tbl.push_back(mk(1'b0,4'b0010,1'b0,4'h0,8'h00,1'b0,1'b0,4'h4,1'b1,16'hFF04,8'h81));
        tbl.push_back(mk(1'b0,4'b0010,1'b1,4'h1,8'h00,1'b0,1'b0,4'h1,1'b1,16'hFF04,8'h00));
        tbl.push_back(mk(1'b0,4'b0010,1'b0,4'h0,8'h00,1'b0,1'b0,4'h0,1'b0,16'h0000,8'h02));
        tbl.push_back(mk(1'b0,4'b0010,1'b1,4'h1,8'h0F,1'b0,1'b0,4'h1,1'b0,16'h0000,8'h0F));
        tbl.push_back(mk(1'b0,4'b0010,1'b0,4'h0,8'h00,1'b0,1'b0,4'h4,1'b1,16'hFF04,8'h81));
        tbl.push_back(mk(1'b0,4'b0010,1'b1,4'h0,8'h02,1'b0,1'b0,4'h0,1'b1,16'hFF04,8'h00));
        tbl.push_back(mk(1'b0,4'b0010,1'b0,4'h0,8'h00,1'b0,1'b0,4'h0,1'b0,16'h0000,8'h00));
        // 5: edge beats software clear and ack clear
        tbl.push_back(mk(1'b0,4'b0000,1'b0,4'h0,8'h00,1'b0,1'b0,4'h0,1'b0,16'h0000,8'h00));
        tbl.push_back(mk(1'b0,4'b0001,1'b1,4'h0,8'h01,1'b0,1'b0,4'h0,1'b0,16'h0000,8'h01));
        tbl.push_back(mk(1'b0,4'b0001,1'b0,4'h0,8'h00,1'b0,1'b0,4'h4,1'b1,16'hFF00,8'h80));
        tbl.push_back(mk(1'b0,4'b0000,1'b0,4'h0,8'h00,1'b0,1'b0,4'h0,1'b1,16'hFF00,8'h01));
        tbl.push_back(mk(1'b0,4'b0001,1'b0,4'h0,8'h00,1'b1,1'b0,4'h2,1'b0,16'h0000,8'h01));
        tbl.push_back(mk(1'b0,4'b0001,1'b0,4'h0,8'h00,1'b0,1'b0,4'h0,1'b0,16'h0000,8'h01));
        tbl.push_back(mk(1'b0,4'b0001,1'b0,4'h0,8'h00,1'b0,1'b1,4'h2,1'b0,16'h0000,8'h00));
        tbl.push_back(mk(1'b0,4'b0001,1'b0,4'h0,8'h00,1'b0,1'b0,4'h4,1'b1,16'hFF00,8'h80));
        // 6: reset mid-handshake, then unmapped / read-only writes ignored
        tbl.push_back(mk(1'b1,4'b0000,1'b0,4'h0,8'h00,1'b0,1'b0,4'h0,1'b0,16'h0000,8'h00));
        tbl.push_back(mk(1'b0,4'b0000,1'b1,4'h5,8'hFF,1'b0,1'b0,4'h5,1'b0,16'h0000,8'h00));
        tbl.push_back(mk(1'b0,4'b0000,1'b1,4'h2,8'h0F,1'b0,1'b0,4'h2,1'b0,16'h0000,8'h00));

        for (int i = 0; i < tbl.size(); i++) begin
            reset    = tbl[i].rst;
            irq_in   = tbl[i].irq;
            enable   = tbl[i].wr;
            mode     = tbl[i].wr;
            address  = tbl[i].waddr;
            data_in  = tbl[i].wdata;
            irq_ack  = tbl[i].ack;
            irq_done = tbl[i].done;
            @(posedge clk);
            #1;
            irq_ack  = 1'b0;
            irq_done = 1'b0;
            enable   = 1'b1;
            mode     = 1'b0;
            address  = tbl[i].raddr;
            #1;
            check($sformatf("vec%0d irq_req", i), 16'(irq_req), 16'(tbl[i].exp_req));
            if (tbl[i].exp_req) begin
                check($sformatf("vec%0d irq_vector", i), irq_vector, tbl[i].exp_vec);
            end
            check($sformatf("vec%0d read_a%0h", i, tbl[i].raddr), 16'(data_out), 16'(tbl[i].exp_rd));
        end

        // After reset: vector cleared, every register reads zero.
        reset = 1'b0;
        check("post_reset irq_vector", irq_vector, 16'h0000);
        for (int a = 0; a < 5; a++) begin
            address = 4'(a);
            #1;
            check($sformatf("post_reset reg%0d", a), 16'(data_out), 16'h0000);
        end

        // Bus not selected, or selected for write: data_out floats.
        enable = 1'b0;
        mode   = 1'b0;
        #1;
        checks++;
        if (data_out !== 8'bzzzzzzzz) begin
            errors++;
            $display("FAIL tristate_disabled got %b want zzzzzzzz", data_out);
        end
        enable  = 1'b1;
        mode    = 1'b1;
        address = 4'h5;
        data_in = 8'h00;
        #1;
        checks++;
        if (data_out !== 8'bzzzzzzzz) begin
            errors++;
            $display("FAIL tristate_write got %b want zzzzzzzz", data_out);
        end
        enable = 1'b0;
        mode   = 1'b0;
        @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
